up_down_timer: RTL and testbench

UP_DOWN_TIMER -- requirements
Module: up_down_timer

---
 rtl/up_down_timer.sv | 180 ++++++++++++++++++
 tb/tb_up_down_timer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/up_down_timer.sv
// up_down_timer: loadable up/down counter with terminal-count pulse,
// auto-reload or one-shot behaviour, and a three-state run controller.
//
// Build option: define UP_DOWN_TIMER_PRESCALE_EN to add a PRESC_WIDTH-bit
// prescaler (and the io_prescale port) that divides the tick rate by
// io_prescale+1. With the macro undefined every cycle in COUNT is a tick.
//
// Load strobe semantics: io_load is a single-cycle strobe with no
// back-pressure. Whenever it is high in a cycle (and reset is low), the
// count takes io_load_val on the next rising edge, that cycle produces no
// tick and no io_tc, and the prescaler restarts from zero.
//
// dbg_state exposes the controller state (0 = IDLE, 1 = COUNT, 2 = DONE).

module up_down_timer #(
    parameter int WIDTH       = 32,
    parameter int PRESC_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_en,
    input  logic                   io_dir,
    input  logic                   io_oneshot,
    input  logic                   io_load,
    input  logic [WIDTH-1:0]       io_load_val,
    input  logic [WIDTH-1:0]       io_count_max,
`ifdef UP_DOWN_TIMER_PRESCALE_EN
    input  logic [PRESC_WIDTH-1:0] io_prescale,
`endif
    output logic [WIDTH-1:0]       io_count,
    output logic                   io_tc,
    output logic                   io_done,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Parameter sanity: both widths must describe at least one bit.
    if (WIDTH < 1 || PRESC_WIDTH < 1) begin : g_bad_param
        $error("up_down_timer: WIDTH and PRESC_WIDTH must be >= 1");
    end

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             tick;
    logic             terminal;

`ifdef UP_DOWN_TIMER_PRESCALE_EN
    logic [PRESC_WIDTH-1:0] presc_q;
    logic [PRESC_WIDTH-1:0] presc_d;
    logic                   presc_hit;

    // Prescaler reaches its divisor. A ">=" compare means lowering
    // io_prescale below the running value fires at once instead of
    // wrapping through the whole prescaler range.
    assign presc_hit = (presc_q >= io_prescale);

    // A tick needs an enabled COUNT cycle, no load, and a prescaler hit.
    assign tick = (state_q == S_COUNT) && io_en && !io_load && presc_hit;

    // Prescaler advances only while actively counting; anything else
    // (leaving COUNT, dropping enable, a load) restarts it from zero.
    always_comb begin
        presc_d = '0;
        if (state_q == S_COUNT && io_en && !io_load) begin
            if (presc_hit) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // Prescaler register.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    // Without a prescaler every enabled, non-load COUNT cycle is a tick.
    // A cycle in which io_en has already dropped is the exit from COUNT
    // and does not advance the count.
    assign tick = (state_q == S_COUNT) && io_en && !io_load;
`endif

    // Terminal condition for the current direction. Counting up, anything
    // at or above the limit is terminal so a loaded value or a lowered
    // limit never lets the count climb past io_count_max.
    always_comb begin
        terminal = 1'b0;
        if (io_dir) begin
            terminal = (count_q == '0);
        end else begin
            terminal = (count_q >= io_count_max);
        end
    end

    // Next count and terminal pulse: load first, then tick, else hold.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (io_load) begin
            count_d = io_load_val;
        end else if (tick) begin
            if (terminal) begin
                tc_d = 1'b1;
                if (io_oneshot) begin
                    count_d = count_q;
                end else if (io_dir) begin
                    count_d = io_count_max;
                end else begin
                    count_d = '0;
                end
            end else if (io_dir) begin
                count_d = count_q - 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Run controller next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (io_en) begin
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (!io_en) begin
                    state_d = S_IDLE;
                end else if (tick && terminal && io_oneshot) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!io_en) begin
                    state_d = S_IDLE;
                end else if (io_load) begin
                    state_d = S_COUNT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, count and pulse registers; reset overrides every input.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign io_count  = count_q;
    assign io_tc     = tc_q;
    assign io_done   = (state_q == S_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_up_down_timer.sv
// Testbench for up_down_timer (WIDTH = 8). A table of per-cycle vectors
// walks through the main scenarios; hand-written sequences cover reset
// versus load, the top-of-range auto-reload, and the prescaler when
// UP_DOWN_TIMER_PRESCALE_EN is defined.

module tb_up_down_timer;

    localparam int W = 8;
    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_C = 2'd1;
    localparam logic [1:0] ST_D = 2'd2;

    // ---------------- clock / reset / DUT ----------------
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         io_en = 1'b0;
    logic         io_dir = 1'b0;
    logic         io_oneshot = 1'b0;
    logic         io_load = 1'b0;
    logic [W-1:0] io_load_val = '0;
    logic [W-1:0] io_count_max = '0;
`ifdef UP_DOWN_TIMER_PRESCALE_EN
    logic [15:0]  io_prescale = '0;
`endif
    logic [W-1:0] io_count;
    logic         io_tc;
    logic         io_done;
    logic [1:0]   dbg_state;

    always #5 clock = ~clock;

    up_down_timer #(.WIDTH(W), .PRESC_WIDTH(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_en        (io_en),
        .io_dir       (io_dir),
        .io_oneshot   (io_oneshot),
        .io_load      (io_load),
        .io_load_val  (io_load_val),
        .io_count_max (io_count_max),
`ifdef UP_DOWN_TIMER_PRESCALE_EN
        .io_prescale  (io_prescale),
`endif
        .io_count     (io_count),
        .io_tc        (io_tc),
        .io_done      (io_done),
        .dbg_state    (dbg_state)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic         rst;
        logic         en;
        logic         dir;
        logic         os;
        logic         ld;
        logic [W-1:0] lv;
        logic [W-1:0] mx;
        logic [W-1:0] cnt;
        logic         tc;
        logic         done;
        logic [1:0]   st;
    } vec_t;

    vec_t vec_q[$];

    task automatic add_vec(input logic rst, input logic en, input logic dir,
                           input logic os, input logic ld, input int lv,
                           input int mx, input int cnt, input logic tc,
                           input logic done, input logic [1:0] st);
        vec_t v;
        v.rst = rst; v.en = en; v.dir = dir; v.os = os; v.ld = ld;
        v.lv = W'(lv); v.mx = W'(mx); v.cnt = W'(cnt);
        v.tc = tc; v.done = done; v.st = st;
        vec_q.push_back(v);
    endtask

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx,
                             input logic [W-1:0] cnt, input logic tc,
                             input logic done, input logic [1:0] st);
        check({tag, ".count"}, idx, 32'(io_count), 32'(cnt));
        check({tag, ".tc"},    idx, 32'(io_tc),    32'(tc));
        check({tag, ".done"},  idx, 32'(io_done),  32'(done));
        check({tag, ".state"}, idx, 32'(dbg_state), 32'(st));
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic rst, input logic en, input logic dir,
                         input logic os, input logic ld,
                         input logic [W-1:0] lv, input logic [W-1:0] mx);
        reset = rst; io_en = en; io_dir = dir; io_oneshot = os;
        io_load = ld; io_load_val = lv; io_count_max = mx;
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ---------------- test ----------------
    initial begin
        logic [W-1:0] exp_cnt;
        logic         exp_tc;
        logic [W-1:0] presc_exp[7];

        //       rst en dir os ld lv  mx   cnt tc done st
        add_vec(1, 0, 0, 0, 0, 0,  3,   0, 0, 0, ST_I); // reset
        add_vec(0, 0, 0, 0, 0, 0,  3,   0, 0, 0, ST_I);
        add_vec(0, 1, 0, 0, 0, 0,  3,   0, 0, 0, ST_C); // up auto-reload
        add_vec(0, 1, 0, 0, 0, 0,  3,   1, 0, 0, ST_C);
        add_vec(0, 1, 0, 0, 0, 0,  3,   2, 0, 0, ST_C);
        add_vec(0, 1, 0, 0, 0, 0,  3,   3, 0, 0, ST_C);
        add_vec(0, 1, 0, 0, 0, 0,  3,   0, 1, 0, ST_C);
        add_vec(0, 1, 0, 0, 0, 0,  3,   1, 0, 0, ST_C);
        add_vec(0, 1, 0, 0, 0, 0,  9,   2, 0, 0, ST_C);
        add_vec(0, 1, 0, 0, 0, 0,  9,   3, 0, 0, ST_C);
        add_vec(0, 1, 0, 0, 0, 0,  9,   4, 0, 0, ST_C);
        add_vec(0, 0, 0, 0, 0, 0,  9,   4, 0, 0, ST_I); // enable drop
        add_vec(0, 0, 0, 0, 0, 0,  9,   4, 0, 0, ST_I);
        add_vec(0, 0, 0, 0, 0, 0,  9,   4, 0, 0, ST_I);
        add_vec(0, 1, 0, 0, 0, 0,  9,   4, 0, 0, ST_C);
        add_vec(0, 1, 0, 0, 0, 0,  9,   5, 0, 0, ST_C);
        add_vec(0, 1, 0, 0, 0, 0,  9,   6, 0, 0, ST_C);
        add_vec(0, 1, 0, 0, 0, 0,  9,   7, 0, 0, ST_C);
        add_vec(1, 1, 0, 0, 0, 0,  9,   0, 0, 0, ST_I); // reset mid-run
        add_vec(0, 1, 0, 0, 0, 0,  0,   0, 0, 0, ST_C); // count_max = 0
        add_vec(0, 1, 0, 0, 0, 0,  0,   0, 1, 0, ST_C);
        add_vec(0, 1, 0, 0, 0, 0,  0,   0, 1, 0, ST_C);
        add_vec(0, 0, 0, 0, 0, 0,  0,   0, 0, 0, ST_I);
        add_vec(0, 1, 1, 1, 1, 2,  0,   2, 0, 0, ST_C); // down one-shot
        add_vec(0, 1, 1, 1, 0, 0,  0,   1, 0, 0, ST_C);
        add_vec(0, 1, 1, 1, 0, 0,  0,   0, 0, 0, ST_C);
        add_vec(0, 1, 1, 1, 0, 0,  0,   0, 1, 1, ST_D);
        add_vec(0, 1, 1, 1, 0, 0,  0,   0, 0, 1, ST_D);
        add_vec(0, 0, 1, 1, 0, 0,  0,   0, 0, 0, ST_I);
        add_vec(0, 1, 1, 0, 0, 0,  4,   0, 0, 0, ST_C); // down auto-reload
        add_vec(0, 1, 1, 0, 0, 0,  4,   4, 1, 0, ST_C);
        add_vec(0, 1, 1, 0, 0, 0,  4,   3, 0, 0, ST_C);
        add_vec(0, 1, 0, 0, 0, 0,  5,   4, 0, 0, ST_C); // load priority
        add_vec(0, 1, 0, 0, 0, 0,  5,   5, 0, 0, ST_C);
        add_vec(0, 1, 0, 0, 1, 10, 5,  10, 0, 0, ST_C);
        add_vec(0, 1, 0, 0, 0, 0,  5,   0, 1, 0, ST_C);
        add_vec(0, 1, 0, 1, 0, 0,  2,   1, 0, 0, ST_C); // up one-shot
        add_vec(0, 1, 0, 1, 0, 0,  2,   2, 0, 0, ST_C);
        add_vec(0, 1, 0, 1, 0, 0,  2,   2, 1, 1, ST_D);
        add_vec(0, 1, 0, 1, 0, 0,  2,   2, 0, 1, ST_D);
        add_vec(0, 1, 0, 1, 1, 7,  2,   7, 0, 0, ST_C); // load in DONE, en=1
        add_vec(0, 1, 0, 1, 0, 0,  2,   7, 1, 1, ST_D);
        add_vec(0, 0, 0, 1, 1, 1,  2,   1, 0, 0, ST_I); // load in DONE, en=0
        add_vec(0, 1, 0, 1, 0, 0,  2,   1, 0, 0, ST_C);
        add_vec(0, 1, 0, 1, 0, 0,  2,   2, 0, 0, ST_C);
        add_vec(0, 1, 0, 1, 0, 0,  2,   2, 1, 1, ST_D);
        add_vec(1, 1, 0, 1, 0, 0,  2,   0, 0, 0, ST_I); // reset in DONE
        add_vec(0, 1, 0, 0, 0, 0,  9,   0, 0, 0, ST_C); // direction change
        add_vec(0, 1, 0, 0, 0, 0,  9,   1, 0, 0, ST_C);
        add_vec(0, 1, 1, 0, 0, 0,  9,   0, 0, 0, ST_C);
        add_vec(0, 1, 1, 0, 0, 0,  9,   9, 1, 0, ST_C);
        add_vec(0, 1, 0, 0, 0, 0,  3,   0, 1, 0, ST_C); // limit lowered
        add_vec(0, 1, 0, 0, 0, 0,  3,   1, 0, 0, ST_C);

        foreach (vec_q[i]) begin
            drive(vec_q[i].rst, vec_q[i].en, vec_q[i].dir, vec_q[i].os,
                  vec_q[i].ld, vec_q[i].lv, vec_q[i].mx);
            step();
            check_all("vec", i, vec_q[i].cnt, vec_q[i].tc, vec_q[i].done, vec_q[i].st);
        end

        // Reset wins over a simultaneous load and enable.
        drive(1, 1, 0, 0, 1, 8'd9, 8'd20);
        step();
        check_all("rst_vs_load", 0, 8'd0, 1'b0, 1'b0, ST_I);

        // Top of range: load 250 with limit 255, count up through the
        // wrap back to 0 with a single tc pulse.
        drive(0, 1, 0, 0, 1, 8'd250, 8'd255);
        step();
        check_all("top", 0, 8'd250, 1'b0, 1'b0, ST_C);
        io_load = 1'b0;
        exp_cnt = 8'd250;
        for (int k = 1; k <= 8; k++) begin
            exp_tc  = (exp_cnt == 8'd255);
            exp_cnt = exp_tc ? 8'd0 : exp_cnt + 8'd1;
            step();
            check_all("top", k, exp_cnt, exp_tc, 1'b0, ST_C);
        end

`ifdef UP_DOWN_TIMER_PRESCALE_EN
        // Prescaler divide-by-3: count advances every third cycle.
        drive(1, 0, 0, 0, 0, 8'd0, 8'd9);
        io_prescale = 16'd2;
        step();
        check_all("presc_rst", 0, 8'd0, 1'b0, 1'b0, ST_I);
        presc_exp = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
        drive(0, 1, 0, 0, 0, 8'd0, 8'd9);
        for (int k = 0; k < 7; k++) begin
            step();
            check("presc.count", k, 32'(io_count), 32'(presc_exp[k]));
        end
        // A load restarts the prescaler: two quiet cycles before next tick.
        io_load = 1'b1; io_load_val = 8'd5;
        step();
        check("presc_ld.count", 0, 32'(io_count), 32'd5);
        io_load = 1'b0;
        step();
        check("presc_ld.count", 1, 32'(io_count), 32'd5);
        step();
        check("presc_ld.count", 2, 32'(io_count), 32'd5);
        step();
        check("presc_ld.count", 3, 32'(io_count), 32'd6);
        io_prescale = 16'd0;
`else
        presc_exp = '{default: '0};
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
